// File: rtl/case_9_prod_accum.sv
// Sums LEN signed products from a valid/ready stream into one exact signed result.
// The transaction is framed by ap_start/ap_ready/ap_done/ap_idle block-level handshakes.
module case_9_prod_accum #(
    parameter int din_WIDTH  = 6,
    parameter int LEN        = 4,
    parameter int dout_WIDTH = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_done,
    output logic                         ap_idle,
    input  logic signed [din_WIDTH-1:0]  in_tdata,
    input  logic                         in_tvalid,
    output logic                         in_tready,
    output logic signed [dout_WIDTH-1:0] out_tdata,
    output logic                         out_tvalid,
    input  logic                         out_tready
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    // The sum must be wide enough to hold LEN worst-case products without wrapping.
    generate
        if (dout_WIDTH < din_WIDTH + $clog2(LEN)) begin : g_width_check
            $error("case_9_prod_accum: dout_WIDTH too narrow for din_WIDTH and LEN");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t                        state;
    logic signed [dout_WIDTH-1:0]  acc;
    logic signed [dout_WIDTH-1:0]  in_ext;
    logic signed [dout_WIDTH-1:0]  acc_sum;
    logic [CNT_W-1:0]              cnt;
    logic                          in_hs;
    logic                          out_hs;

    assign in_ext    = dout_WIDTH'(in_tdata);
    assign acc_sum   = acc + in_ext;
    assign ap_idle   = (state == S_IDLE);
    assign in_tready = (state == S_ACC);
    assign in_hs     = in_tvalid & in_tready;
    assign out_hs    = out_tvalid & out_tready;

    // ap_ready and ap_done default low each cycle so each can only ever pulse.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ap_ready   <= 1'b0;
            ap_done    <= 1'b0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
        end else begin
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state    <= S_ACC;
                        acc      <= '0;
                        cnt      <= '0;
                        ap_ready <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (in_hs) begin
                        acc <= acc_sum;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            out_tdata  <= acc_sum;
                            out_tvalid <= 1'b1;
                            state      <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        out_tvalid <= 1'b0;
                        ap_done    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
